rtype_decode_rf: RTL
====================

Name: rtype_decode_rf

Overview:
- Decode/operand-fetch stage directly upstream of the R-type ALU.
- Accepts 32-bit RV32I instructions over a valid/ready handshake and decodes the R-type opcode into the ALU's ten one-hot enables.
- Reads a 32-entry register file and presents registered operands plus destination register to the ALU stage.
- Also owns the register file write port, which is fed by the ALU result through writeback.

Parameters:
- XLEN, 32, data width of registers and operands.
- NREGS, 32, number of architectural registers; index width is log2(NREGS); x0 is hardwired to zero.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  upstream instruction valid.
- instr  in  32  instruction word.
- instr_ready  out  1  stage can accept instruction this cycle.
- ex_valid  out  1  operands/enables valid toward ALU stage.
- ex_ready  in  1  ALU stage consumes the current ex bundle.
- Radd_en, Rsub_en, Ror_en, Rxor_en, Rand_en, Rslt_en, Rsltu_en, Rsll_en, Rsrl_en, Rsra_en  out  1 each  registered one-hot ALU enables.
- read_data1  out  XLEN  registered rs1 operand.
- read_data2  out  XLEN  registered rs2 operand; shifts are masked to [4:0].
- ex_rd  out  5  registered destination index.
- illegal  out  1  registered flag: the current bundle was not a legal R-type instruction.
- wb_en  in  1  register file write enable.
- wb_rd  in  5  write index.
- wb_data  in  XLEN  write data (ALU result).

Behaviour:
- Reset is asynchronous and active-high; one clock.
  - Every register file entry resets to 0.
  - ex_valid=0, all enables=0, read_data1/2=0, ex_rd=0, illegal=0.
- Handshake:
  - instr_ready = (!ex_valid | ex_ready) & !hazard_stall.
  - An instruction is accepted on a cycle where instr_valid & instr_ready.
  - The ex bundle updates on the following edge. Latency is 1 cycle from accept to ex_valid.
  - If ex_valid & !ex_ready, the ex bundle holds stable.
  - On a cycle where ex fires with no accept, ex_valid clears at the next edge.
- Decode requires opcode 0110011; otherwise the instruction is illegal. Legal {funct7, funct3} combinations:
  - 0000000/000 add
  - 0100000/000 sub
  - 0000000/001 sll
  - 0000000/010 slt
  - 0000000/011 sltu
  - 0000000/100 xor
  - 0000000/101 srl
  - 0100000/101 sra
  - 0000000/110 or
  - 0000000/111 and
  - Any other combination is illegal.
- Legal instruction: exactly one enable is set, ex_rd=instr[11:7], illegal=0.
- Illegal instruction:
  - It is still consumed; ex_valid=1, all enables=0, ex_rd=0, illegal=1.
  - No hazard check is applied.
- Operands:
  - rs1=instr[19:15], rs2=instr[24:20].
  - Index 0 always reads 0.
  - For sll/srl/sra, read_data2 = {27'b0, rf[rs2][4:0]}; all other ops pass rf[rs2] unmodified.
- Register file write:
  - On a rising edge with wb_en=1 and wb_rd!=0, rf[wb_rd] <= wb_data.
  - wb_rd=0 is ignored.
  - Writeback is asserted by the downstream stage in the same cycle the ex bundle fires.
- Reset mid-operation: the in-flight ex bundle is discarded; the first accept after reset deassertion sees a zeroed register file.

Optional Feature:
- RF_WB_BYPASS_EN defined:
  - When an accepted legal instruction's rs matches wb_rd, with wb_en=1 and wb_rd!=0, the operand takes wb_data instead of rf[rs].
  - hazard_stall is held at 0, so dependent back-to-back instructions issue with zero bubbles.
- RF_WB_BYPASS_EN undefined:
  - No bypass.
  - hazard_stall=1 when ex_valid, ex_rd!=0, the incoming instruction is legal, and rs1==ex_rd or rs2==ex_rd.
  - This causes a one-bubble interlock; the operand is read from the updated register file on the next cycle.

Decomposition:
- Shared package rtype_pkg holds:
  - OPC_RTYPE = 7'b0110011.
  - F7_BASE and F7_ALT.
  - funct3 constants.
  - An enum or index constants for the ten ALU ops, with the one-hot ordering add, sub, or, xor, and, slt, sltu, sll, srl, sra.
  - XLEN default.
- One sub-module is natural: rtype_regfile (2 async read ports, 1 sync write port, x0 hardwired, async reset).
- Decode and pipeline register stay in the top level.

Test Plan:
- Reset, then write wb x1=5 and x2=3; accept add x3,x1,x2 (0x002081B3) -> next cycle ex_valid=1, Radd_en=1 only, read_data1=5, read_data2=3, ex_rd=3.
- Set x5=0xFFFF_FF25; accept sll x6,x1,x5 -> Rsll_en=1, read_data2=0x0000_0005. Then sra with funct7=0100000 -> Rsra_en=1.
- Dependent pair: add x3,x1,x2, then sub x4,x3,x1, with wb of x3=8 in the same cycle ex fires:
  - With RF_WB_BYPASS_EN: no bubble, read_data1=8.
  - Without: instr_ready low for 1 cycle, then read_data1=8.
- Hold ex_ready=0 for 3 cycles with instr_valid=1 -> instr_ready=0, ex bundle stable; on release, the next instruction is accepted.
- Accept opcode 0010011 and funct7=0000001 add-form -> illegal=1, all enables 0, ex_rd=0. A wb to x0 of 0xDEAD leaves x0 reading 0.
- Assert rst while ex_valid=1 -> ex_valid=0 and outputs 0 immediately (async); x1 reads 0 afterwards.

Source files
------------

// File: rtl/rtype_decode_rf_pkg.sv
// Shared constants for the R-type decode/operand-fetch stage: opcode/funct fields,
// one-hot ALU enable ordering and the R-type decode helper.
package rtype_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NUM_OPS  = 10;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Bit positions of the one-hot enable vector, matching the ALU's port order.
    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_OR   = 2;
    localparam int OP_XOR  = 3;
    localparam int OP_AND  = 4;
    localparam int OP_SLT  = 5;
    localparam int OP_SLTU = 6;
    localparam int OP_SLL  = 7;
    localparam int OP_SRL  = 8;
    localparam int OP_SRA  = 9;

    typedef logic [NUM_OPS-1:0] alu_en_t;

    // Returns all-zero for anything that is not a legal R-type instruction.
    function automatic alu_en_t decode_rtype(input logic [31:0] ins);
        alu_en_t en;
        en = '0;
        if (ins[6:0] == OPC_RTYPE) begin
            case ({ins[31:25], ins[14:12]})
                {F7_BASE, F3_ADD_SUB}: en[OP_ADD]  = 1'b1;
                {F7_ALT,  F3_ADD_SUB}: en[OP_SUB]  = 1'b1;
                {F7_BASE, F3_SLL}:     en[OP_SLL]  = 1'b1;
                {F7_BASE, F3_SLT}:     en[OP_SLT]  = 1'b1;
                {F7_BASE, F3_SLTU}:    en[OP_SLTU] = 1'b1;
                {F7_BASE, F3_XOR}:     en[OP_XOR]  = 1'b1;
                {F7_BASE, F3_SR}:      en[OP_SRL]  = 1'b1;
                {F7_ALT,  F3_SR}:      en[OP_SRA]  = 1'b1;
                {F7_BASE, F3_OR}:      en[OP_OR]   = 1'b1;
                {F7_BASE, F3_AND}:     en[OP_AND]  = 1'b1;
                default:               en          = '0;
            endcase
        end
        return en;
    endfunction

endpackage

// File: rtl/rtype_decode_rf_if.sv
// Bundle between fetch, this decode stage, the ALU stage and writeback.
// Handshake: a transfer happens on any rising edge where valid & ready are both high;
// a producer holding valid keeps its payload stable until that edge, and ready may depend on valid.
interface rtype_decode_rf_if
    import rtype_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            instr_valid;
    logic [31:0]     instr;
    logic            instr_ready;

    logic            ex_valid;
    logic            ex_ready;
    logic            Radd_en, Rsub_en, Ror_en, Rxor_en, Rand_en;
    logic            Rslt_en, Rsltu_en, Rsll_en, Rsrl_en, Rsra_en;
    logic [XLEN-1:0] read_data1;
    logic [XLEN-1:0] read_data2;
    logic [4:0]      ex_rd;
    logic            illegal;

    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    modport slave (
        input  instr_valid, instr, ex_ready, wb_en, wb_rd, wb_data,
        output instr_ready, ex_valid,
               Radd_en, Rsub_en, Ror_en, Rxor_en, Rand_en,
               Rslt_en, Rsltu_en, Rsll_en, Rsrl_en, Rsra_en,
               read_data1, read_data2, ex_rd, illegal
    );

    modport master (
        output instr_valid, instr, ex_ready, wb_en, wb_rd, wb_data,
        input  instr_ready, ex_valid,
               Radd_en, Rsub_en, Ror_en, Rxor_en, Rand_en,
               Rslt_en, Rsltu_en, Rsll_en, Rsrl_en, Rsra_en,
               read_data1, read_data2, ex_rd, illegal
    );

endinterface

// File: rtl/rtype_decode_rf_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous write port,
// x0 hardwired to zero, every entry cleared by the asynchronous reset.
module rtype_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] rf_q [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : rf_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : rf_q[raddr2_i];

endmodule

// File: rtl/rtype_decode_rf.sv
// R-type decode / operand-fetch stage feeding the ALU. Build option RF_WB_BYPASS_EN forwards
// writeback data to the operands instead of interlocking on a dependence with the ex bundle.
module rtype_decode_rf
    import rtype_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = 32
) (
    input logic               clk,
    input logic               rst,
    rtype_decode_rf_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] rf_rd1, rf_rd2;
    alu_en_t         en_d, en_q;
    logic            legal, shift_op, hazard_stall, accept, fire;
    logic [XLEN-1:0] op1_d, op2_raw, op2_d, rd1_q, rd2_q;
    logic [4:0]      ex_rd_d, ex_rd_q;
    logic            ex_valid_q, illegal_q;

    assign rs1 = bus.instr[19:15];
    assign rs2 = bus.instr[24:20];

    rtype_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we_i     (bus.wb_en),
        .waddr_i  (bus.wb_rd[AW-1:0]),
        .wdata_i  (bus.wb_data),
        .raddr1_i (rs1[AW-1:0]),
        .raddr2_i (rs2[AW-1:0]),
        .rdata1_o (rf_rd1),
        .rdata2_o (rf_rd2)
    );

    assign en_d     = decode_rtype(bus.instr);
    assign legal    = |en_d;
    assign shift_op = en_d[OP_SLL] | en_d[OP_SRL] | en_d[OP_SRA];
    assign ex_rd_d  = legal ? bus.instr[11:7] : 5'd0;

`ifdef RF_WB_BYPASS_EN
    // Writeback lands in the same cycle the older bundle fires, so forward it straight in.
    always_comb begin
        op1_d        = rf_rd1;
        op2_raw      = rf_rd2;
        hazard_stall = 1'b0;
        if (legal && bus.wb_en && (bus.wb_rd != 5'd0)) begin
            if (bus.wb_rd == rs1) op1_d   = bus.wb_data;
            if (bus.wb_rd == rs2) op2_raw = bus.wb_data;
        end
    end
`else
    // Interlock for one cycle; by then writeback has updated the register file.
    always_comb begin
        op1_d        = rf_rd1;
        op2_raw      = rf_rd2;
        hazard_stall = ex_valid_q && (ex_rd_q != 5'd0) && legal &&
                       ((rs1 == ex_rd_q) || (rs2 == ex_rd_q));
    end
`endif

    assign op2_d = shift_op ? {{(XLEN-5){1'b0}}, op2_raw[4:0]} : op2_raw;

    assign bus.instr_ready = (!ex_valid_q || bus.ex_ready) && !hazard_stall;
    assign accept          = bus.instr_valid && bus.instr_ready;
    assign fire            = ex_valid_q && bus.ex_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            en_q       <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            ex_rd_q    <= '0;
            illegal_q  <= 1'b0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            en_q       <= en_d;
            rd1_q      <= op1_d;
            rd2_q      <= op2_d;
            ex_rd_q    <= ex_rd_d;
            illegal_q  <= !legal;
        end else if (fire) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign bus.ex_valid   = ex_valid_q;
    assign bus.Radd_en    = en_q[OP_ADD];
    assign bus.Rsub_en    = en_q[OP_SUB];
    assign bus.Ror_en     = en_q[OP_OR];
    assign bus.Rxor_en    = en_q[OP_XOR];
    assign bus.Rand_en    = en_q[OP_AND];
    assign bus.Rslt_en    = en_q[OP_SLT];
    assign bus.Rsltu_en   = en_q[OP_SLTU];
    assign bus.Rsll_en    = en_q[OP_SLL];
    assign bus.Rsrl_en    = en_q[OP_SRL];
    assign bus.Rsra_en    = en_q[OP_SRA];
    assign bus.read_data1 = rd1_q;
    assign bus.read_data2 = rd2_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.illegal    = illegal_q;

endmodule
